regfile_dump_reader: RTL and testbench

Sequential read-side controller for the processor's 32×32 register file. On a start pulse it walks a configurable register range through the register file's asynchronous read port, one address at a time. Each word is presented on a valid/ready output stream together with its index. A running XOR checksum is kept for the dump. The block sits beside the datapath as a debug/test port: it only reads, and the datapath's write port stays live during a dump.

---
 rtl/regfile_dump_reader.sv | 114 +++++++++++
 tb/tb_regfile_dump_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Walks register indices FIRST_REG..LAST_REG through the register file's
// asynchronous read port and streams each word out on a valid/ready
// interface together with its index. A running XOR checksum covers every
// accepted word of the current (or most recent) dump.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; clears all state
//   start      - request a dump (only honoured while idle)
//   rf_addr    - register file read address
//   rf_data    - register file read data for rf_addr (same cycle)
//   out_valid  - out_data/out_index hold a word
//   out_ready  - consumer accepts the word on out_valid && out_ready
//   out_data   - captured register value
//   out_index  - register index of out_data
//   busy       - dump in progress (fetch, send or done)
//   done       - one-cycle pulse at the end of a dump
//   checksum   - XOR of all words accepted in the current/last dump
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  index_q, index_d;
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    index_d    = index_q;
    checksum_d = checksum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d      = FirstIdx;
          checksum_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        // Capture here so later datapath writes cannot disturb the word.
        data_d  = rf_data;
        index_d = idx_q;
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          checksum_d = checksum_q ^ data_q;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      data_q     <= '0;
      index_q    <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      index_q    <= index_d;
      checksum_q <= checksum_d;
    end
  end

  assign rf_addr   = idx_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = data_q;
  assign out_index = index_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [31:0] regs [32];

  // Full-range instance (0..31)
  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [4:0]  rf_addr_a, index_a;
  logic [31:0] rf_data_a, data_a, cks_a;
  // Partial-range instance (3..5)
  logic        start_b, ready_b, valid_b, busy_b, done_b;
  logic [4:0]  rf_addr_b, index_b;
  logic [31:0] rf_data_b, data_b, cks_b;

  assign rf_data_a = (rf_addr_a == 5'd0) ? 32'h0 : regs[rf_addr_a];
  assign rf_data_b = (rf_addr_b == 5'd0) ? 32'h0 : regs[rf_addr_b];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rf_addr(rf_addr_a), .rf_data(rf_data_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_index(index_a),
    .busy(busy_a), .done(done_a), .checksum(cks_a)
  );

  regfile_dump_reader #(.FIRST_REG(3), .LAST_REG(5)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rf_addr(rf_addr_b), .rf_data(rf_data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_index(index_b),
    .busy(busy_b), .done(done_b), .checksum(cks_b)
  );

  // Monitor view of the instance selected by sel
  logic        sel;
  logic        m_valid, m_busy, m_done;
  logic [4:0]  m_index;
  logic [31:0] m_data, m_cks;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_index = sel ? index_b : index_a;
  assign m_data  = sel ? data_b  : data_a;
  assign m_cks   = sel ? cks_b   : cks_a;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent dump
  int          got_idx[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_data[32];
  int          n_stable_err, n_done, done_cycle, first_valid_cycle;
  logic        busy_after, busy_late;

  function automatic logic [31:0] rf_val(input int i);
    return (i == 0) ? 32'h0 : regs[i];
  endfunction

  function automatic logic [31:0] exp_checksum(input int first, input int last);
    logic [31:0] c = 32'h0;
    for (int i = first; i <= last; i++) c = c ^ exp_data[i];
    return c;
  endfunction

  task automatic preload();
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h100 + i;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // Pulse start, then observe cycles 1.. at falling edges, recording accepted words.
  // ready_mode: 0 = always 1, 1 = 1,0,0 pattern, 2 = random.
  // wr_mode: 1 = write reg20 before its fetch, 2 = write reg20 after its fetch.
  task automatic run_dump(input int ready_mode, input bit midstart, input int wr_mode);
    logic rdy, acc, prev_valid, prev_acc;
    logic [31:0] prev_data;
    logic [4:0]  prev_index;
    got_idx.delete();
    got_data.delete();
    n_stable_err = 0; n_done = 0; done_cycle = -1; first_valid_cycle = -1;
    busy_after = 1'bx; busy_late = 1'bx;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_data = '0; prev_index = '0;
    @(negedge clk);
    set_start(1'b1);
    ready_a = 1'b1; ready_b = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      set_start(midstart && cyc >= 10 && cyc <= 12);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_a = rdy; ready_b = rdy;
      if (prev_valid && !prev_acc &&
          (!m_valid || m_data !== prev_data || m_index !== prev_index)) n_stable_err++;
      if (m_valid && first_valid_cycle < 0) first_valid_cycle = cyc;
      acc = m_valid && rdy;
      if (acc) begin
        got_idx.push_back(int'(m_index));
        got_data.push_back(m_data);
      end
      if (wr_mode == 1 && acc && m_index == 5'd15) regs[20] = 32'hDEADBEEF;
      if (wr_mode == 2 && m_valid && m_index == 5'd20) regs[20] = 32'hCAFEF00D;
      if (m_done) begin
        n_done++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc == done_cycle + 1) busy_after = m_busy;
      if (done_cycle >= 0 && cyc == done_cycle + 4) begin
        busy_late = m_busy;
        break;
      end
      prev_valid = m_valid; prev_acc = acc; prev_data = m_data; prev_index = m_index;
    end
    set_start(1'b0);
    ready_a = 1'b1; ready_b = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b1; start_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rf_addr_a !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    n_checks++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_a); end
    n_checks++; if (index_a !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", index_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_checks++; if (cks_a !== 32'h0) begin n_fail++; $display("FAIL reset_checksum: got %h want 0", cks_a); end
    n_checks++; if (rf_addr_b !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr_partial: got %0d want 0", rf_addr_b); end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_dump: got busy=%b valid=%b want 0/0", busy_a, valid_a);
    end
  endtask

  task automatic test_full_dump();
    preload();
    for (int i = 0; i < 32; i++) exp_data[i] = rf_val(i);
    sel = 1'b0;
    run_dump(0, 1'b0, 0);
    n_checks++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d want 32", got_idx.size()); end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL full_word[%0d]: got idx %0d data %h want idx %0d data %h",
                           i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    n_checks++; if (first_valid_cycle != 2) begin n_fail++; $display("FAIL full_first_valid: got %0d want 2", first_valid_cycle); end
    n_checks++; if (done_cycle != 65) begin n_fail++; $display("FAIL full_done_cycle: got %0d want 65", done_cycle); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", n_done); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy_after); end
    n_checks++; if (m_cks !== 32'h100) begin n_fail++; $display("FAIL full_checksum: got %h want 00000100", m_cks); end
  endtask

  task automatic test_backpressure();
    preload();
    for (int i = 0; i < 32; i++) exp_data[i] = rf_val(i);
    sel = 1'b0;
    run_dump(1, 1'b0, 0);
    n_checks++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL bp_count: got %0d want 32", got_idx.size()); end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL bp_word[%0d]: got idx %0d data %h want idx %0d data %h",
                           i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    n_checks++; if (n_stable_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations want 0", n_stable_err); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", n_done); end
    n_checks++; if (m_cks !== 32'h100) begin n_fail++; $display("FAIL bp_checksum: got %h want 00000100", m_cks); end
  endtask

  task automatic test_random();
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 32; i++) exp_data[i] = rf_val(i);
    sel = 1'b0;
    run_dump(2, 1'b0, 0);
    n_checks++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL rnd_count: got %0d want 32", got_idx.size()); end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL rnd_word[%0d]: got idx %0d data %h want idx %0d data %h",
                           i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    n_checks++; if (n_stable_err != 0) begin n_fail++; $display("FAIL rnd_stable: got %0d violations want 0", n_stable_err); end
    n_checks++; if (m_cks !== exp_checksum(0, 31)) begin
      n_fail++; $display("FAIL rnd_checksum: got %h want %h", m_cks, exp_checksum(0, 31));
    end
  endtask

  task automatic test_partial();
    preload();
    for (int i = 0; i < 32; i++) exp_data[i] = rf_val(i);
    sel = 1'b1;
    run_dump(0, 1'b0, 0);
    n_checks++; if (got_idx.size() != 3) begin n_fail++; $display("FAIL part_count: got %0d want 3", got_idx.size()); end
    for (int i = 0; i < got_idx.size() && i < 3; i++) begin
      n_checks++;
      if (got_idx[i] != i + 3 || got_data[i] !== exp_data[i + 3]) begin
        n_fail++; $display("FAIL part_word[%0d]: got idx %0d data %h want idx %0d data %h",
                           i, got_idx[i], got_data[i], i + 3, exp_data[i + 3]);
      end
    end
    n_checks++; if (done_cycle != 7) begin n_fail++; $display("FAIL part_done_cycle: got %0d want 7", done_cycle); end
    n_checks++; if (m_cks !== 32'h102) begin n_fail++; $display("FAIL part_checksum: got %h want 00000102", m_cks); end
    sel = 1'b0;
  endtask

  task automatic test_start_busy_and_writes();
    preload();
    for (int i = 0; i < 32; i++) exp_data[i] = rf_val(i);
    exp_data[20] = 32'hDEADBEEF;
    sel = 1'b0;
    run_dump(0, 1'b1, 1);
    n_checks++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL midstart_count: got %0d want 32", got_idx.size()); end
    n_checks++; if (got_idx.size() > 0 && got_idx[0] != 0) begin n_fail++; $display("FAIL midstart_first: got %0d want 0", got_idx[0]); end
    n_checks++; if (busy_late !== 1'b0) begin n_fail++; $display("FAIL midstart_no_queue: got busy %b want 0", busy_late); end
    n_checks++; if (got_data.size() > 20 && got_data[20] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_before_fetch: got %h want deadbeef", got_data[20]);
    end
    n_checks++; if (m_cks !== exp_checksum(0, 31)) begin
      n_fail++; $display("FAIL write_before_checksum: got %h want %h", m_cks, exp_checksum(0, 31));
    end
    preload();
    run_dump(0, 1'b0, 2);
    n_checks++; if (got_data.size() > 20 && got_data[20] !== 32'h114) begin
      n_fail++; $display("FAIL write_after_fetch: got %h want 00000114", got_data[20]);
    end
    n_checks++; if (m_cks !== 32'h100) begin n_fail++; $display("FAIL write_after_checksum: got %h want 00000100", m_cks); end
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 1'b0;
    preload();
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a && index_a == 5'd10) begin
        hit = 1'b1;
        reset = 1'b1;
      end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL midreset_reach: got no send at index 10 want one"); end
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", valid_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
    n_checks++; if (cks_a !== 32'h0) begin n_fail++; $display("FAIL midreset_checksum: got %h want 0", cks_a); end
    n_checks++; if (index_a !== 5'd0) begin n_fail++; $display("FAIL midreset_index: got %0d want 0", index_a); end
    run_dump(0, 1'b0, 0);
    n_checks++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL midreset_redump_count: got %0d want 32", got_idx.size()); end
    n_checks++; if (got_idx.size() > 0 && got_idx[0] != 0) begin n_fail++; $display("FAIL midreset_redump_first: got %0d want 0", got_idx[0]); end
    n_checks++; if (cks_a !== 32'h100) begin n_fail++; $display("FAIL midreset_redump_checksum: got %h want 00000100", cks_a); end
  endtask

  initial begin
    preload();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_random();
    test_partial();
    test_start_busy_and_writes();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
